// File: rtl/typing_round_counter.sv
// Round controller for the typing game: BCD score/miss counters, a per-second
// countdown and per-digit ready flags feeding six 7-segment decoders.
`timescale 1ns/1ps
module typing_round_counter #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int ROUND_SECS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [7:0] score_bcd,
    output logic [7:0] miss_bcd,
    output logic [7:0] time_bcd,
    output logic [5:0] disp_rdy,
    output logic       running,
    output logic       game_over,
    output logic [1:0] dbg_state
);

    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRE_MAX   = PW'(CLK_HZ - 1);
    localparam logic [7:0]      TIME_INIT = {4'(ROUND_SECS / 10), 4'(ROUND_SECS % 10)};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t        r_state;
    logic [7:0]    r_score;
    logic [7:0]    r_miss;
    logic [7:0]    r_time;
    logic [PW-1:0] r_presc;
    logic [5:0]    r_disp_rdy;
    logic          r_running;
    logic          r_game_over;

    logic          w_tick;
    logic [7:0]    w_score_nxt;
    logic [7:0]    w_miss_nxt;
    logic [7:0]    w_time_nxt;
    logic [PW-1:0] w_presc_nxt;

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    always_comb begin
        w_tick      = (r_presc == PRE_MAX);
        w_score_nxt = hit ? bcd_inc_sat(r_score) : r_score;
        w_miss_nxt  = miss ? bcd_inc_sat(r_miss) : r_miss;
        w_time_nxt  = w_tick ? bcd_dec(r_time) : r_time;
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
    end

    // Flags are derived from the next digit values so digit and flag land together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_score     <= 8'h00;
            r_miss      <= 8'h00;
            r_time      <= TIME_INIT;
            r_presc     <= '0;
            r_disp_rdy  <= 6'b000000;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_score     <= 8'h00;
                        r_miss      <= 8'h00;
                        r_time      <= TIME_INIT;
                        r_presc     <= '0;
                        r_running   <= 1'b1;
                        r_game_over <= 1'b0;
                        r_disp_rdy  <= {1'b0, 1'b1, 1'b0, 1'b1,
                                        (TIME_INIT[7:4] != 4'd0), 1'b1};
                    end
                end
                ST_RUN: begin
                    r_score    <= w_score_nxt;
                    r_miss     <= w_miss_nxt;
                    r_time     <= w_time_nxt;
                    r_presc    <= w_presc_nxt;
                    r_disp_rdy <= {(w_score_nxt[7:4] != 4'd0), 1'b1,
                                   (w_miss_nxt[7:4] != 4'd0), 1'b1,
                                   (w_time_nxt[7:4] != 4'd0), 1'b1};
                    if (w_tick && (w_time_nxt == 8'h00)) begin
                        r_state     <= ST_OVER;
                        r_running   <= 1'b0;
                        r_game_over <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign score_bcd = r_score;
    assign miss_bcd  = r_miss;
    assign time_bcd  = r_time;
    assign disp_rdy  = r_disp_rdy;
    assign running   = r_running;
    assign game_over = r_game_over;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_typing_round_counter.sv
// Directed bench for typing_round_counter: a short-round instance (4 Hz, 3 s)
// and a long-round instance (100 Hz, 99 s) checked against a queue of expectations.
`timescale 1ns/1ps
module tb_typing_round_counter;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;

    logic       a_start, a_hit, a_miss;
    logic [7:0] a_score, a_missc, a_time;
    logic [5:0] a_rdy;
    logic       a_running, a_over;
    logic [1:0] a_dbg;

    logic       b_start, b_hit, b_miss;
    logic [7:0] b_score, b_missc, b_time;
    logic [5:0] b_rdy;
    logic       b_running, b_over;
    logic [1:0] b_dbg;

    logic [W-1:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    typing_round_counter #(.CLK_HZ(4), .ROUND_SECS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .hit(a_hit), .miss(a_miss),
        .score_bcd(a_score), .miss_bcd(a_missc), .time_bcd(a_time),
        .disp_rdy(a_rdy), .running(a_running), .game_over(a_over), .dbg_state(a_dbg)
    );

    typing_round_counter #(.CLK_HZ(100), .ROUND_SECS(99)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .hit(b_hit), .miss(b_miss),
        .score_bcd(b_score), .miss_bcd(b_missc), .time_bcd(b_time),
        .disp_rdy(b_rdy), .running(b_running), .game_over(b_over), .dbg_state(b_dbg)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_a(input logic s, input logic h, input logic m);
        a_start = s; a_hit = h; a_miss = m;
        @(negedge clk);
        a_start = 1'b0; a_hit = 1'b0; a_miss = 1'b0;
    endtask

    task automatic drive_b(input logic s, input logic h, input logic m);
        b_start = s; b_hit = h; b_miss = m;
        @(negedge clk);
        b_start = 1'b0; b_hit = 1'b0; b_miss = 1'b0;
    endtask

    // scoreboard
    task automatic expect_v(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: got %0h with no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: got %0h expected %0h", tag, obs, e);
        end
    endtask

    initial begin
        logic prev_rdy1;
        int   guard;

        rst_n = 1'b0;
        a_start = 1'b0; a_hit = 1'b0; a_miss = 1'b0;
        b_start = 1'b0; b_hit = 1'b0; b_miss = 1'b0;
        step(3);
        rst_n = 1'b1;

        // idle for 20 cycles; hits must be ignored
        expect_v(8'h00); expect_v(8'h03); expect_v(8'h00); expect_v(8'h00);
        expect_v(8'h00); expect_v(8'h00); expect_v(8'h99); expect_v(8'h00);
        expect_v(8'h00);
        for (int i = 0; i < 20; i++) drive_a(1'b0, (i % 3) == 0, 1'b0);
        chk("idle_a_rdy",     W'(a_rdy));
        chk("idle_a_time",    a_time);
        chk("idle_a_running", W'(a_running));
        chk("idle_a_over",    W'(a_over));
        chk("idle_a_score",   a_score);
        chk("idle_a_state",   W'(a_dbg));
        chk("idle_b_time",    b_time);
        chk("idle_b_rdy",     W'(b_rdy));
        chk("idle_b_state",   W'(b_dbg));

        // short round: start, three ticks every 4 edges, hit on the final tick
        expect_v(8'h01); expect_v(8'h03); expect_v(8'b0001_0101); expect_v(8'h00);
        drive_a(1'b1, 1'b0, 1'b0);
        chk("start_a_running", W'(a_running));
        chk("start_a_time",    a_time);
        chk("start_a_rdy",     W'(a_rdy));
        chk("start_a_over",    W'(a_over));
        expect_v(8'h03);
        step(3);
        chk("pre_tick1_time", a_time);
        expect_v(8'h02);
        step(1);
        chk("tick1_time", a_time);
        expect_v(8'h01);
        step(4);
        chk("tick2_time", a_time);
        expect_v(8'h01); expect_v(8'h01);
        step(3);
        chk("pre_final_time",    a_time);
        chk("pre_final_running", W'(a_running));
        expect_v(8'h00); expect_v(8'h01); expect_v(8'h00); expect_v(8'h01);
        expect_v(8'b0001_0101);
        drive_a(1'b0, 1'b1, 1'b0);
        chk("final_time",    a_time);
        chk("final_over",    W'(a_over));
        chk("final_running", W'(a_running));
        chk("final_hit",     a_score);
        chk("final_rdy",     W'(a_rdy));

        // long round: BCD carries, tens blanking, 10 -> 09 transition, saturation
        expect_v(8'h13); expect_v(8'h04); expect_v(8'b0011_0111); expect_v(8'h99);
        drive_b(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) drive_b(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)  drive_b(1'b0, 1'b0, 1'b1);
        drive_b(1'b0, 1'b1, 1'b1);
        chk("b_score13", b_score);
        chk("b_miss04",  b_missc);
        chk("b_rdy13",   W'(b_rdy));
        chk("b_time99",  b_time);

        guard = 0;
        while (b_time !== 8'h10 && guard < 10000) begin
            step(1);
            guard++;
        end
        prev_rdy1 = b_rdy[1];
        guard = 0;
        while (b_time === 8'h10 && guard < 200) begin
            prev_rdy1 = b_rdy[1];
            step(1);
            guard++;
        end
        expect_v(8'h01); expect_v(8'h09); expect_v(8'b0011_0101);
        chk("b_rdy1_before", W'(prev_rdy1));
        chk("b_time09",      b_time);
        chk("b_rdy09",       W'(b_rdy));

        expect_v(8'h63);
        b_hit = 1'b1;
        step(50);
        chk("b_score63", b_score);
        expect_v(8'h99); expect_v(8'b0011_0101);
        step(55);
        b_hit = 1'b0;
        chk("b_score_sat", b_score);
        chk("b_rdy_sat",   W'(b_rdy));

        // OVER: hits/misses ignored, then start with a simultaneous hit clears
        expect_v(8'h01); expect_v(8'h00); expect_v(8'h01);
        drive_a(1'b0, 1'b1, 1'b1);
        chk("over_score_frozen", a_score);
        chk("over_miss_frozen",  a_missc);
        chk("over_still_over",   W'(a_over));
        expect_v(8'h00); expect_v(8'h03); expect_v(8'h01); expect_v(8'h00);
        expect_v(8'h00);
        drive_a(1'b1, 1'b1, 1'b0);
        chk("restart_score",   a_score);
        chk("restart_time",    a_time);
        chk("restart_running", W'(a_running));
        chk("restart_over",    W'(a_over));
        chk("restart_miss",    a_missc);

        // start during RUN is ignored; prescaler keeps its phase
        step(2);
        expect_v(8'h03); expect_v(8'h01); expect_v(8'h01);
        drive_a(1'b1, 1'b1, 1'b0);
        chk("run_start_time",    a_time);
        chk("run_start_score",   a_score);
        chk("run_start_running", W'(a_running));
        expect_v(8'h02);
        step(1);
        chk("run_start_tick", a_time);

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_v(8'h00); expect_v(8'h00); expect_v(8'h03); expect_v(8'h00);
        expect_v(8'h00); expect_v(8'h00);
        chk("arst_score",   a_score);
        chk("arst_miss",    a_missc);
        chk("arst_time",    a_time);
        chk("arst_rdy",     W'(a_rdy));
        chk("arst_running", W'(a_running));
        chk("arst_over",    W'(a_over));
        step(1);
        rst_n = 1'b1;
        step(2);

        // final report
        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL queue_drain: got %0d leftover expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
